// File: rtl/mask_bound_encoder_512bit_pkg.sv
// Shared types and constants for the connected-domain mask encode/decode logic.
package conn_domain_pkg;

    localparam int MASK_W = 512;
    localparam int IDX_W  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/mask_bound_encoder_512bit_if.sv
// Trigger/result bundle between a requester and the mask bound encoder.
interface mask_bound_encoder_512bit_if;
    import conn_domain_pkg::*;

    logic              i_trig;
    logic [MASK_W-1:0] i_mask;
    logic              o_done;
    logic              o_left_or_right;
    logic [IDX_W-1:0]  o_bound_index;
    logic              o_err;

    modport master (
        output i_trig, i_mask,
        input  o_done, o_left_or_right, o_bound_index, o_err
    );

    modport slave (
        input  i_trig, i_mask,
        output o_done, o_left_or_right, o_bound_index, o_err
    );

endinterface

// File: rtl/mask_bound_encoder_512bit_therm.sv
// Combinational thermometer builder: idx ones packed against the MSB (left) or LSB (right).
module therm_mask_build #(
    parameter int MASK_W = 512,
    parameter int IDX_W  = 9
) (
    input  logic              dir,
    input  logic [IDX_W-1:0]  idx,
    output logic [MASK_W-1:0] mask
);
    import conn_domain_pkg::*;

    always_comb begin
        mask = '0;
        if (dir == DIR_RIGHT) begin
            mask = ~({MASK_W{1'b1}} << idx);
        end else begin
            mask = ~({MASK_W{1'b1}} >> idx);
        end
    end

endmodule

// File: rtl/mask_bound_encoder_512bit.sv
// Recovers fill side and ones count from a one-sided mask: 9-step binary search, then legality check.
// Result appears 11 cycles after the trigger is sampled and holds until the trigger is released.
module mask_bound_encoder_512bit #(
    parameter int MASK_W = 512,
    parameter int IDX_W  = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    mask_bound_encoder_512bit_if.slave bus
);
    import conn_domain_pkg::*;

    localparam int STEP_W = $clog2(IDX_W);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_CHECK  = CHECK;
    localparam logic [1:0] S_DONE   = DONE;

    logic [1:0]        state;
    logic [MASK_W-1:0] mask_l;
    logic [IDX_W-1:0]  idx;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic              err_r;

    logic [IDX_W-1:0]  trial;
    logic [IDX_W-1:0]  left_pos;
    logic [IDX_W-1:0]  right_pos;
    logic              trial_hit;
    logic [MASK_W-1:0] ref_mask;
    logic              ref_bad;

    // trial is never 0, so MASK_W-trial wraps correctly in IDX_W bits and trial-1 never underflows.
    always_comb begin
        trial     = idx | (IDX_W'(1) << step);
        left_pos  = IDX_W'(0) - trial;
        right_pos = trial - IDX_W'(1);
        trial_hit = (dir == DIR_RIGHT) ? mask_l[right_pos] : mask_l[left_pos];
    end

    therm_mask_build #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_therm (
        .dir  (dir),
        .idx  (idx),
        .mask (ref_mask)
    );

    // Both ends set can never be a one-sided mask, even if the search result happens to rebuild it.
    assign ref_bad = (ref_mask != mask_l) || (mask_l[MASK_W-1] && mask_l[0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            mask_l <= '0;
            idx    <= '0;
            dir    <= 1'b0;
            step   <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_trig) begin
                        mask_l <= bus.i_mask;
                        dir    <= !bus.i_mask[MASK_W-1] && bus.i_mask[0];
                        idx    <= '0;
                        step   <= STEP_W'(IDX_W - 1);
                        err_r  <= 1'b0;
                        state  <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (trial_hit) begin
                        idx <= trial;
                    end
                    if (step == '0) begin
                        state <= S_CHECK;
                    end else begin
                        step <= step - STEP_W'(1);
                    end
                end
                S_CHECK: begin
                    err_r <= ref_bad;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.i_trig) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_done          = (state == S_DONE);
    assign bus.o_left_or_right = (state == S_DONE) ? dir   : 1'b0;
    assign bus.o_bound_index   = (state == S_DONE) ? idx   : '0;
    assign bus.o_err           = (state == S_DONE) ? err_r : 1'b0;

endmodule

// File: tb/tb_mask_bound_encoder_512bit.sv
// Randomized and directed checks of the mask bound encoder against a popcount/thermometer reference.
module tb_mask_bound_encoder_512bit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    mask_bound_encoder_512bit_if mif();

    mask_bound_encoder_512bit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int popc(input logic [511:0] m);
        int c;
        c = 0;
        for (int i = 0; i < 512; i++) c += int'(m[i]);
        return c;
    endfunction

    // A mask is legal when it equals the thermometer of its own popcount on the side it is filled from.
    function automatic bit model_err(input logic [511:0] m);
        logic [511:0] t;
        bit           right;
        int           k;
        if (m[511] && m[0]) return 1'b1;
        right = !m[511] && m[0];
        k     = popc(m);
        t     = '0;
        for (int i = 0; i < k; i++) begin
            if (right) t[i] = 1'b1;
            else       t[511 - i] = 1'b1;
        end
        return t != m;
    endfunction

    function automatic logic [511:0] therm(input bit right, input int k);
        logic [511:0] t;
        t = '0;
        for (int i = 0; i < k; i++) begin
            if (right) t[i] = 1'b1;
            else       t[511 - i] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [511:0] rand_mask();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_done0"}, int'(mif.o_done), 0);
        chk({tag, "_dir0"},  int'(mif.o_left_or_right), 0);
        chk({tag, "_idx0"},  int'(mif.o_bound_index), 0);
        chk({tag, "_err0"},  int'(mif.o_err), 0);
    endtask

    task automatic run_op(input string tag, input logic [511:0] m, input bit pulse);
        int lat;
        int e_dir;
        int e_err;
        int e_idx;
        e_dir = int'(!m[511] && m[0]);
        e_err = int'(model_err(m));
        e_idx = (m == {512{1'b1}}) ? 511 : popc(m);

        @(negedge clk);
        mif.i_mask = m;
        mif.i_trig = 1'b1;
        lat = 0;
        if (pulse) begin
            @(posedge clk);
            #1;
            lat = 1;
            mif.i_trig = 1'b0;
            mif.i_mask = ~m;
        end
        while (mif.o_done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_dir"}, int'(mif.o_left_or_right), e_dir);
        chk({tag, "_err"}, int'(mif.o_err), e_err);
        if (e_err == 0 || m == {512{1'b1}}) begin
            chk({tag, "_idx"}, int'(mif.o_bound_index), e_idx);
        end

        if (pulse) begin
            @(posedge clk);
            #1;
            check_idle({tag, "_after_pulse"});
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_done"}, int'(mif.o_done), 1);
                chk({tag, "_hold_err"},  int'(mif.o_err), e_err);
            end
            @(negedge clk);
            mif.i_trig = 1'b0;
            @(posedge clk);
            #1;
            check_idle({tag, "_release"});
        end
    endtask

    initial begin
        logic [511:0] m;
        int           k;
        bit           side;
        int           pos;

        n_chk  = 0;
        n_pass = 0;
        rst        = 1'b1;
        mif.i_trig = 1'b0;
        mif.i_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        m = 512'hF8;
        run_op("top5", m << 504, 1'b0);
        run_op("low300", therm(1'b1, 300), 1'b0);
        run_op("zero", '0, 1'b0);
        run_op("ones", {512{1'b1}}, 1'b0);
        m = 512'h1;
        run_op("iso100", m << 100, 1'b0);
        run_op("left511", therm(1'b0, 511), 1'b0);
        run_op("bit0", m, 1'b0);
        m = therm(1'b0, 40);
        m[200] = 1'b1;
        run_op("hole", m, 1'b0);

        // Reset landing on the search step-4 cycle.
        @(negedge clk);
        mif.i_mask = therm(1'b1, 77);
        mif.i_trig = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mif.i_trig = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_stays_idle", int'(mif.o_done), 0);
        run_op("retrig511", therm(1'b0, 511), 1'b0);

        run_op("pulse", therm(1'b1, 123), 1'b1);

        for (int n = 0; n < 14; n++) begin
            k    = $urandom_range(0, 511);
            side = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd_legal%0d", n), therm(side, k), 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 6; n++) begin
            k    = $urandom_range(1, 511);
            side = 1'($urandom_range(0, 1));
            m    = therm(side, k);
            pos  = $urandom_range(0, 511);
            m[pos] = ~m[pos];
            run_op($sformatf("rnd_flip%0d", n), m, 1'b0);
        end
        for (int n = 0; n < 4; n++) begin
            run_op($sformatf("rnd_noise%0d", n), rand_mask(), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
